// File: rtl/axi_rd_arbiter_if.sv
// -----------------------------------------------------------------------------
// axi_rd_arbiter_if
// Bundles the signals between the three cache-side read requesters, the AXI
// bridge read-request port, the write-back hazard source, and the read arbiter.
//
// Signals
//   s_raddr   [2:0][31:0] per-requester read address {req2,req1,req0}
//   s_rlen    [2:0][7:0]  per-requester burst length (beats-1)
//   s_rsize   [2:0][2:0]  per-requester beat size (log2 bytes)
//   s_rvalid  [2:0]       request valid, held until the matching s_rready
//   s_rready  [2:0]       one-cycle completion pulse to the granted requester
//   s_rdata   [511:0]     line data, meaningful only while a s_rready bit is high
//   m_raddr   [31:0]      address to the bridge
//   m_rlen    [7:0]       burst length to the bridge
//   m_rsize   [2:0]       beat size to the bridge
//   m_rvalid              request to the bridge, held until m_rready
//   m_rready              bridge completion pulse (last beat accepted)
//   m_rdata   [511:0]     bridge line data, valid with m_rready
//   wb_busy               dcache write-back in flight
//   wb_addr   [31:0]      address of the in-flight write-back
//   grant_id  [1:0]       requester currently served, 3 when idle
//
// Modports
//   slave  : the arbiter itself (serves the requesters)
//   master : the surrounding environment (requesters, bridge, write-back FSM)
// -----------------------------------------------------------------------------
interface axi_rd_arbiter_if;
    logic [2:0][31:0] s_raddr;
    logic [2:0][7:0]  s_rlen;
    logic [2:0][2:0]  s_rsize;
    logic [2:0]       s_rvalid;
    logic [2:0]       s_rready;
    logic [511:0]     s_rdata;
    logic [31:0]      m_raddr;
    logic [7:0]       m_rlen;
    logic [2:0]       m_rsize;
    logic             m_rvalid;
    logic             m_rready;
    logic [511:0]     m_rdata;
    logic             wb_busy;
    logic [31:0]      wb_addr;
    logic [1:0]       grant_id;

    modport slave (
        input  s_raddr, s_rlen, s_rsize, s_rvalid, m_rready, m_rdata, wb_busy, wb_addr,
        output s_rready, s_rdata, m_raddr, m_rlen, m_rsize, m_rvalid, grant_id
    );

    modport master (
        output s_raddr, s_rlen, s_rsize, s_rvalid, m_rready, m_rdata, wb_busy, wb_addr,
        input  s_rready, s_rdata, m_raddr, m_rlen, m_rsize, m_rvalid, grant_id
    );
endinterface

// File: rtl/axi_rd_arbiter.sv
// -----------------------------------------------------------------------------
// axi_rd_arbiter
// Arbitrates three cache-side read requesters (0=dcache, 1=uncached, 2=icache)
// onto the single read-request port of the AXI bridge. One line read is
// outstanding at a time; the completion pulse and line data are routed back to
// the granted requester. A request whose line matches the in-flight dcache
// write-back is held off (read-after-write hazard).
//
// Ports
//   clk   clock
//   rst   synchronous reset, active-high
//   bus   axi_rd_arbiter_if.slave (requester, bridge and write-back signals)
//
// Parameters
//   LINE_OFF    low address bits ignored by the hazard compare (64 B line)
//   STARVE_MAX  consecutive non-icache grants while icache waits before the
//               icache is forced to win
//
// Build option
//   AXI_RD_RR_EN  when defined, fixed priority and the starvation counter are
//                 replaced by round-robin starting after the last grant.
// -----------------------------------------------------------------------------
module axi_rd_arbiter #(
    parameter int LINE_OFF   = 6,
    parameter int STARVE_MAX = 4
) (
    input  logic            clk,
    input  logic            rst,
    axi_rd_arbiter_if.slave bus
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    localparam logic [1:0] GRANT_NONE = 2'd3;

    state_t      state_r;
    state_t      state_nxt_s;
    logic [31:0] m_raddr_r;
    logic [31:0] m_raddr_nxt_s;
    logic [7:0]  m_rlen_r;
    logic [7:0]  m_rlen_nxt_s;
    logic [2:0]  m_rsize_r;
    logic [2:0]  m_rsize_nxt_s;
    logic        m_rvalid_r;
    logic        m_rvalid_nxt_s;
    logic [1:0]  grant_id_r;
    logic [1:0]  grant_id_nxt_s;
    logic        abandon_r;
    logic        abandon_nxt_s;
    logic [2:0]  eligible_s;
    logic [1:0]  winner_s;
    logic        grant_fire_s;
    logic        grant_valid_s;
    logic [2:0]  s_rready_s;
    logic        wb_addr_unused_s;

    // First eligible requester in the order a, b, c (c is the fallback).
    function automatic logic [1:0] pick3(input logic [2:0] elig,
                                         input logic [1:0] a,
                                         input logic [1:0] b,
                                         input logic [1:0] c);
        logic [1:0] res;
        if (elig[a]) begin
            res = a;
        end else if (elig[b]) begin
            res = b;
        end else begin
            res = c;
        end
        return res;
    endfunction

    // Line offset bits of the write-back address play no part in the hazard.
    assign wb_addr_unused_s = ^bus.wb_addr[LINE_OFF-1:0];

    // A request is eligible unless its line collides with the write-back in flight.
    always_comb begin
        eligible_s = 3'b000;
        for (int i = 0; i < 3; i++) begin
            if (bus.s_rvalid[i] &&
                !(bus.wb_busy && (bus.s_raddr[i][31:LINE_OFF] == bus.wb_addr[31:LINE_OFF]))) begin
                eligible_s[i] = 1'b1;
            end else begin
                eligible_s[i] = 1'b0;
            end
        end
    end

    assign grant_fire_s = (state_r == ST_IDLE) && (|eligible_s);

`ifdef AXI_RD_RR_EN
    logic [1:0] last_grant_r;

    // Round-robin: search starts one past the last granted requester.
    always_comb begin
        case (last_grant_r)
            2'd0:    winner_s = pick3(eligible_s, 2'd1, 2'd2, 2'd0);
            2'd1:    winner_s = pick3(eligible_s, 2'd2, 2'd0, 2'd1);
            default: winner_s = pick3(eligible_s, 2'd0, 2'd1, 2'd2);
        endcase
    end

    // Remember the most recent winner for the next round-robin search.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_r <= 2'd2;
        end else if (grant_fire_s) begin
            last_grant_r <= winner_s;
        end else begin
            last_grant_r <= last_grant_r;
        end
    end
`else
    localparam int               CNT_W      = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    logic [CNT_W-1:0] starve_cnt_r;

    // Fixed priority dcache > uncached > icache, unless the icache has starved.
    always_comb begin
        if ((starve_cnt_r == STARVE_LIM) && eligible_s[2]) begin
            winner_s = 2'd2;
        end else begin
            winner_s = pick3(eligible_s, 2'd0, 2'd1, 2'd2);
        end
    end

    // Count grants that bypass a waiting, unblocked icache; saturates at the limit.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt_r <= '0;
        end else if (!bus.s_rvalid[2]) begin
            starve_cnt_r <= '0;
        end else if (grant_fire_s && (winner_s == 2'd2)) begin
            starve_cnt_r <= '0;
        end else if (grant_fire_s && eligible_s[2] && (starve_cnt_r != STARVE_LIM)) begin
            starve_cnt_r <= starve_cnt_r + CNT_ONE;
        end else begin
            starve_cnt_r <= starve_cnt_r;
        end
    end
`endif

    // Whether the currently granted requester still asserts its request.
    always_comb begin
        case (grant_id_r)
            2'd0:    grant_valid_s = bus.s_rvalid[0];
            2'd1:    grant_valid_s = bus.s_rvalid[1];
            2'd2:    grant_valid_s = bus.s_rvalid[2];
            default: grant_valid_s = 1'b0;
        endcase
    end

    // Completion pulse follows m_rready in the same cycle; abandoned reads get none.
    always_comb begin
        s_rready_s = 3'b000;
        if ((state_r == ST_BUSY) && bus.m_rready && grant_valid_s && !abandon_r) begin
            case (grant_id_r)
                2'd0:    s_rready_s = 3'b001;
                2'd1:    s_rready_s = 3'b010;
                2'd2:    s_rready_s = 3'b100;
                default: s_rready_s = 3'b000;
            endcase
        end else begin
            s_rready_s = 3'b000;
        end
    end

    // Next-state and next-output logic of the request FSM.
    always_comb begin
        state_nxt_s    = state_r;
        m_raddr_nxt_s  = m_raddr_r;
        m_rlen_nxt_s   = m_rlen_r;
        m_rsize_nxt_s  = m_rsize_r;
        m_rvalid_nxt_s = m_rvalid_r;
        grant_id_nxt_s = grant_id_r;
        abandon_nxt_s  = abandon_r;
        case (state_r)
            ST_IDLE: begin
                if (grant_fire_s) begin
                    state_nxt_s    = ST_BUSY;
                    m_raddr_nxt_s  = bus.s_raddr[winner_s];
                    m_rlen_nxt_s   = bus.s_rlen[winner_s];
                    m_rsize_nxt_s  = bus.s_rsize[winner_s];
                    m_rvalid_nxt_s = 1'b1;
                    grant_id_nxt_s = winner_s;
                    abandon_nxt_s  = 1'b0;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                // The burst cannot be cancelled: a dropped request is only
                // marked abandoned and its completion is swallowed.
                if (bus.m_rready) begin
                    state_nxt_s    = ST_IDLE;
                    m_rvalid_nxt_s = 1'b0;
                    grant_id_nxt_s = GRANT_NONE;
                    abandon_nxt_s  = 1'b0;
                end else if (!grant_valid_s) begin
                    abandon_nxt_s = 1'b1;
                end else begin
                    abandon_nxt_s = abandon_r;
                end
            end
            default: begin
                state_nxt_s    = ST_IDLE;
                m_rvalid_nxt_s = 1'b0;
                grant_id_nxt_s = GRANT_NONE;
                abandon_nxt_s  = 1'b0;
            end
        endcase
    end

    // FSM state and registered bridge/debug outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            m_raddr_r  <= 32'h0000_0000;
            m_rlen_r   <= 8'h00;
            m_rsize_r  <= 3'b000;
            m_rvalid_r <= 1'b0;
            grant_id_r <= GRANT_NONE;
            abandon_r  <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            m_raddr_r  <= m_raddr_nxt_s;
            m_rlen_r   <= m_rlen_nxt_s;
            m_rsize_r  <= m_rsize_nxt_s;
            m_rvalid_r <= m_rvalid_nxt_s;
            grant_id_r <= grant_id_nxt_s;
            abandon_r  <= abandon_nxt_s;
        end
    end

    assign bus.m_raddr  = m_raddr_r;
    assign bus.m_rlen   = m_rlen_r;
    assign bus.m_rsize  = m_rsize_r;
    assign bus.m_rvalid = m_rvalid_r;
    assign bus.grant_id = grant_id_r;
    assign bus.s_rready = s_rready_s;
    assign bus.s_rdata  = bus.m_rdata;

endmodule
